// File: rtl/fb_pkg.sv
// fb_pkg: 640x480@60 raster timing constants, framebuffer depth and host FSM encoding
package fb_pkg;
    localparam logic [9:0]  H_ACTIVE = 10'd640;
    localparam logic [9:0]  H_FP     = 10'd16;
    localparam logic [9:0]  H_SYNC   = 10'd96;
    localparam logic [9:0]  H_BP     = 10'd48;
    localparam logic [9:0]  H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam logic [9:0]  V_ACTIVE = 10'd480;
    localparam logic [9:0]  V_FP     = 10'd10;
    localparam logic [9:0]  V_SYNC   = 10'd2;
    localparam logic [9:0]  V_BP     = 10'd33;
    localparam logic [9:0]  V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam logic [31:0] FB_DEPTH = 32'd307200;
    typedef logic [15:0] rgb565_t;
    typedef enum logic {HOST_IDLE, HOST_RD} host_state_t;
endpackage

// File: rtl/fb_vga_timing.sv
// fb_vga_timing: 800x525 raster counters with active window, raw syncs and first-pixel flag
module fb_vga_timing
    import fb_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       scan_en,
    output logic [9:0] h_cnt,
    output logic [9:0] v_cnt,
    output logic       active,
    output logic       hsync_raw_n,
    output logic       vsync_raw_n,
    output logic       first_pix
);
    logic [9:0] h_cnt_d, h_cnt_q, v_cnt_d, v_cnt_q;
    logic       h_last;
    // next raster position (parked at origin while disabled) and decoded window/syncs
    always_comb begin
        h_last      = h_cnt_q == H_TOTAL - 10'd1;
        h_cnt_d     = (!scan_en || h_last) ? 10'd0 : h_cnt_q + 10'd1;
        v_cnt_d     = !scan_en ? 10'd0 : !h_last ? v_cnt_q :
                      (v_cnt_q == V_TOTAL - 10'd1) ? 10'd0 : v_cnt_q + 10'd1;
        h_cnt       = h_cnt_q;
        v_cnt       = v_cnt_q;
        active      = scan_en && h_cnt_q < H_ACTIVE && v_cnt_q < V_ACTIVE;
        hsync_raw_n = !(scan_en && h_cnt_q >= H_ACTIVE + H_FP && h_cnt_q < H_ACTIVE + H_FP + H_SYNC);
        vsync_raw_n = !(scan_en && v_cnt_q >= V_ACTIVE + V_FP && v_cnt_q < V_ACTIVE + V_FP + V_SYNC);
        first_pix   = active && h_cnt_q == 10'd0 && v_cnt_q == 10'd0;
    end
    // raster position register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h_cnt_q <= 10'd0;
            v_cnt_q <= 10'd0;
        end else begin
            h_cnt_q <= h_cnt_d;
            v_cnt_q <= v_cnt_d;
        end
    end
endmodule

// File: rtl/framebuffer_scan_ctrl.sv
// framebuffer_scan_ctrl: VGA scan-out of the framebuffer ROM with host readback in blanking
module framebuffer_scan_ctrl
    import fb_pkg::*;
#(
    parameter int          WIDTH = 16,
    parameter logic [31:0] DEPTH = FB_DEPTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             scan_en,
    output logic [31:0]      rom_addr,
    input  logic [WIDTH-1:0] rom_data,
    output logic [WIDTH-1:0] pix_data,
    output logic             pix_de,
    output logic             hsync_n,
    output logic             vsync_n,
    output logic             frame_start,
    input  logic             host_req,
    input  logic [31:0]      host_addr,
    output logic             host_gnt,
    output logic             host_rvalid,
    output logic [WIDTH-1:0] host_rdata,
    output logic             host_err
);
    logic [9:0]       h_cnt, v_cnt;
    logic             active, hs_raw_n, vs_raw_n, first_pix, frame_last;
    logic [18:0]      pix_addr_d, pix_addr_q;
    logic             de1_d, de1_q, hs1_d, hs1_q, vs1_d, vs1_q, fs1_d, fs1_q;
    logic [WIDTH-1:0] pix_data_d, pix_data_q;
    host_state_t      state_d, state_q;
    logic [31:0]      host_addr_d, host_addr_q;
    logic             host_rvalid_d, host_rvalid_q, host_err_d, host_err_q;
    logic [WIDTH-1:0] host_rdata_d, host_rdata_q;

    fb_vga_timing u_timing (
        .clk         (clk),
        .rst_n       (rst_n),
        .scan_en     (scan_en),
        .h_cnt       (h_cnt),
        .v_cnt       (v_cnt),
        .active      (active),
        .hsync_raw_n (hs_raw_n),
        .vsync_raw_n (vs_raw_n),
        .first_pix   (first_pix)
    );

    // pixel address tracking and ROM port arbitration; video always owns active cycles
    always_comb begin
        frame_last = h_cnt == H_TOTAL - 10'd1 && v_cnt == V_TOTAL - 10'd1;
        pix_addr_d = (!scan_en || frame_last) ? 19'd0 : active ? pix_addr_q + 19'd1 : pix_addr_q;
        host_gnt   = state_q == HOST_IDLE && host_req && !active;
        rom_addr   = active ? {13'd0, pix_addr_q} : host_gnt ? host_addr : 32'd0;
    end
    // two-stage video pipeline: stage 1 waits out the ROM read, stage 2 captures the pixel
    always_comb begin
        de1_d      = active;
        hs1_d      = hs_raw_n;
        vs1_d      = vs_raw_n;
        fs1_d      = first_pix;
        pix_data_d = de1_q ? rom_data : '0;
    end
    // host read FSM: latch address on grant, capture ROM data on the following cycle
    always_comb begin
        state_d       = state_q;
        host_addr_d   = host_addr_q;
        host_rvalid_d = 1'b0;
        host_rdata_d  = host_rdata_q;
        host_err_d    = host_err_q;
        if (state_q == HOST_RD) begin
            state_d       = HOST_IDLE;
            host_rvalid_d = 1'b1;
            host_rdata_d  = rom_data;
            host_err_d    = host_addr_q >= DEPTH;
        end else if (host_gnt) begin
            state_d     = HOST_RD;
            host_addr_d = host_addr;
        end
    end
    // state and pipeline registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pix_addr_q    <= 19'd0;
            de1_q         <= 1'b0;
            hs1_q         <= 1'b1;
            vs1_q         <= 1'b1;
            fs1_q         <= 1'b0;
            pix_data_q    <= '0;
            pix_de        <= 1'b0;
            hsync_n       <= 1'b1;
            vsync_n       <= 1'b1;
            frame_start   <= 1'b0;
            state_q       <= HOST_IDLE;
            host_addr_q   <= 32'd0;
            host_rvalid_q <= 1'b0;
            host_rdata_q  <= '0;
            host_err_q    <= 1'b0;
        end else begin
            pix_addr_q    <= pix_addr_d;
            de1_q         <= de1_d;
            hs1_q         <= hs1_d;
            vs1_q         <= vs1_d;
            fs1_q         <= fs1_d;
            pix_data_q    <= pix_data_d;
            pix_de        <= de1_q;
            hsync_n       <= hs1_q;
            vsync_n       <= vs1_q;
            frame_start   <= fs1_q;
            state_q       <= state_d;
            host_addr_q   <= host_addr_d;
            host_rvalid_q <= host_rvalid_d;
            host_rdata_q  <= host_rdata_d;
            host_err_q    <= host_err_d;
        end
    end
    assign pix_data    = pix_data_q;
    assign host_rvalid = host_rvalid_q;
    assign host_rdata  = host_rdata_q;
    assign host_err    = host_err_q;
endmodule

// File: tb/tb_framebuffer_scan_ctrl.sv
// tb_framebuffer_scan_ctrl: vectors, hand sequences and randomized host traffic against a raster model
module tb_framebuffer_scan_ctrl;
    localparam int DEPTH = 307200;
    localparam int NT    = 18;

    typedef struct {
        bit          de;
        logic [15:0] pix;
        bit          hs_n, vs_n, fs, rv;
        logic [15:0] rd;
        bit          er;
    } out_t;

    typedef struct {
        int          k;
        logic [31:0] addr;
        bit          de;
        logic [15:0] pix;
        bit          hs_n, fs, rv;
        logic [15:0] rd;
        bit          er;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n, scan_en, host_req;
    logic [31:0] host_addr, rom_addr;
    logic [15:0] rom_data = 16'd0;
    logic [15:0] pix_data, host_rdata;
    logic        pix_de, hsync_n, vsync_n, frame_start, host_gnt, host_rvalid, host_err;

    int          checks = 0;
    int          failures = 0;
    int          p = 0;
    bit          busy = 1'b0;
    bit          g_e = 1'b0;
    bit          pend = 1'b0;
    logic [31:0] paddr = 32'd0;
    out_t        pipe[$];
    vec_t        tab[NT];

    always #5 clk = ~clk;

    framebuffer_scan_ctrl dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .scan_en     (scan_en),
        .rom_addr    (rom_addr),
        .rom_data    (rom_data),
        .pix_data    (pix_data),
        .pix_de      (pix_de),
        .hsync_n     (hsync_n),
        .vsync_n     (vsync_n),
        .frame_start (frame_start),
        .host_req    (host_req),
        .host_addr   (host_addr),
        .host_gnt    (host_gnt),
        .host_rvalid (host_rvalid),
        .host_rdata  (host_rdata),
        .host_err    (host_err)
    );

    // ramp-image ROM: word n holds n[15:0], out-of-range reads return 0
    always @(posedge clk) rom_data <= (rom_addr < DEPTH) ? rom_addr[15:0] : 16'd0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic out_t rst_out();
        out_t o;
        o.de = 1'b0; o.pix = 16'd0; o.hs_n = 1'b1; o.vs_n = 1'b1;
        o.fs = 1'b0; o.rv = 1'b0; o.rd = 16'd0; o.er = 1'b0;
        return o;
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 3))
            0, 1:    return 32'($urandom_range(0, DEPTH - 1));
            2:       return 32'(DEPTH) + 32'($urandom_range(0, 3));
            default: return $urandom;
        endcase
    endfunction

    // one clock: drive inputs after the edge, sample mid-cycle, compare with the raster model
    task automatic cycle(input bit r_n, input bit en, input bit req, input logic [31:0] addr);
        int   h, v;
        bit   act;
        out_t o, n;
        @(posedge clk);
        #1;
        rst_n = r_n; scan_en = en; host_req = req; host_addr = addr;
        @(negedge clk);
        h   = p % 800;
        v   = p / 800;
        act = r_n && en && h < 640 && v < 480;
        g_e = r_n && !busy && req && !act;
        chk("rom_addr", rom_addr, act ? 32'(v * 640 + h) : (g_e ? addr : 32'd0));
        chk("host_gnt", 32'(host_gnt), 32'(g_e));
        if (!r_n) begin
            o = rst_out();
            pipe = {o, o};
            p = 0;
            busy = 1'b0;
        end else begin
            o = pipe.pop_front();
            n.de   = act;
            n.pix  = act ? 16'(v * 640 + h) : 16'd0;
            n.hs_n = !(en && h >= 656 && h < 752);
            n.vs_n = !(en && v >= 490 && v < 492);
            n.fs   = act && p == 0;
            n.rv   = g_e;
            n.rd   = (g_e && addr < DEPTH) ? addr[15:0] : 16'd0;
            n.er   = g_e && addr >= DEPTH;
            pipe.push_back(n);
            busy = g_e;
            p = en ? (p + 1) % 420000 : 0;
        end
        chk("pix_de", 32'(pix_de), 32'(o.de));
        chk("pix_data", 32'(pix_data), 32'(o.pix));
        chk("hsync_n", 32'(hsync_n), 32'(o.hs_n));
        chk("vsync_n", 32'(vsync_n), 32'(o.vs_n));
        chk("frame_start", 32'(frame_start), 32'(o.fs));
        chk("host_rvalid", 32'(host_rvalid), 32'(o.rv));
        if (o.rv || !r_n) begin
            chk("host_rdata", 32'(host_rdata), 32'(o.rd));
            chk("host_err", 32'(host_err), 32'(o.er));
        end
    endtask

    // host agent: optionally raise a random request, hold it until granted
    task automatic step(input bit r_n, input bit en, input bit rnd);
        if (rnd && !pend && $urandom_range(0, 3) == 0) begin
            pend = 1'b1;
            paddr = pick();
        end
        cycle(r_n, en, r_n && pend, (r_n && pend) ? paddr : $urandom);
        if (g_e || !r_n) pend = 1'b0;
    endtask

    initial begin
        int ti = 0;
        rst_n = 1'b0; scan_en = 1'b0; host_req = 1'b0; host_addr = 32'd0;
        tab[0]  = '{0,    32'd0,      1'b0, 16'd0,   1'b1, 1'b0, 1'b0, 16'd0,     1'b0};
        tab[1]  = '{1,    32'd1,      1'b0, 16'd0,   1'b1, 1'b0, 1'b0, 16'd0,     1'b0};
        tab[2]  = '{2,    32'd2,      1'b1, 16'd0,   1'b1, 1'b1, 1'b0, 16'd0,     1'b0};
        tab[3]  = '{3,    32'd3,      1'b1, 16'd1,   1'b1, 1'b0, 1'b0, 16'd0,     1'b0};
        tab[4]  = '{639,  32'd639,    1'b1, 16'd637, 1'b1, 1'b0, 1'b0, 16'd0,     1'b0};
        tab[5]  = '{640,  32'd1234,   1'b1, 16'd638, 1'b1, 1'b0, 1'b0, 16'd0,     1'b0};
        tab[6]  = '{641,  32'd0,      1'b1, 16'd639, 1'b1, 1'b0, 1'b0, 16'd0,     1'b0};
        tab[7]  = '{642,  32'd0,      1'b0, 16'd0,   1'b1, 1'b0, 1'b1, 16'h04D2,  1'b0};
        tab[8]  = '{645,  32'd307200, 1'b0, 16'd0,   1'b1, 1'b0, 1'b0, 16'd0,     1'b0};
        tab[9]  = '{647,  32'd0,      1'b0, 16'd0,   1'b1, 1'b0, 1'b1, 16'd0,     1'b1};
        tab[10] = '{657,  32'd0,      1'b0, 16'd0,   1'b1, 1'b0, 1'b0, 16'd0,     1'b0};
        tab[11] = '{658,  32'd0,      1'b0, 16'd0,   1'b0, 1'b0, 1'b0, 16'd0,     1'b0};
        tab[12] = '{753,  32'd0,      1'b0, 16'd0,   1'b0, 1'b0, 1'b0, 16'd0,     1'b0};
        tab[13] = '{754,  32'd0,      1'b0, 16'd0,   1'b1, 1'b0, 1'b0, 16'd0,     1'b0};
        tab[14] = '{800,  32'd640,    1'b0, 16'd0,   1'b1, 1'b0, 1'b0, 16'd0,     1'b0};
        tab[15] = '{802,  32'd642,    1'b1, 16'd640, 1'b1, 1'b0, 1'b0, 16'd0,     1'b0};
        tab[16] = '{2399, 32'd77,     1'b0, 16'd0,   1'b1, 1'b0, 1'b0, 16'd0,     1'b0};
        tab[17] = '{2401, 32'd1921,   1'b0, 16'd0,   1'b1, 1'b0, 1'b1, 16'd77,    1'b0};
        repeat (5) step(1'b0, 1'b0, 1'b0);
        // continuous scan from reset: vectors, blocked host request, out-of-range read, last-blank grant
        for (int k = 0; k < 3000; k++) begin
            if (k == 10) begin pend = 1'b1; paddr = 32'd1234; end
            if (k == 645) begin pend = 1'b1; paddr = 32'(DEPTH); end
            if (k == 2399) begin pend = 1'b1; paddr = 32'd77; end
            step(1'b1, 1'b1, k >= 900 && !(k >= 2390 && k < 2400));
            if (ti < NT && tab[ti].k == k) begin
                chk($sformatf("vec%0d_rom_addr", k), rom_addr, tab[ti].addr);
                chk($sformatf("vec%0d_pix_de", k), 32'(pix_de), 32'(tab[ti].de));
                chk($sformatf("vec%0d_pix_data", k), 32'(pix_data), 32'(tab[ti].pix));
                chk($sformatf("vec%0d_hsync_n", k), 32'(hsync_n), 32'(tab[ti].hs_n));
                chk($sformatf("vec%0d_frame_start", k), 32'(frame_start), 32'(tab[ti].fs));
                chk($sformatf("vec%0d_host_rvalid", k), 32'(host_rvalid), 32'(tab[ti].rv));
                if (tab[ti].rv) begin
                    chk($sformatf("vec%0d_host_rdata", k), 32'(host_rdata), 32'(tab[ti].rd));
                    chk($sformatf("vec%0d_host_err", k), 32'(host_err), 32'(tab[ti].er));
                end
                ti++;
            end
        end
        chk("vec_all_applied", 32'(ti), 32'(NT));
        // scan_en dropped mid-line: two cycles of drain, then host owns the ROM
        for (int j = 0; j < 20; j++) begin
            step(1'b1, 1'b0, 1'b1);
            if (j == 1) chk("drain_de", 32'(pix_de), 32'd1);
            if (j == 2) begin
                chk("drained_de", 32'(pix_de), 32'd0);
                chk("drained_pix", 32'(pix_data), 32'd0);
            end
        end
        // re-enable restarts at (0,0), then async reset at h_cnt=300
        for (int j = 0; j < 300; j++) begin
            step(1'b1, 1'b1, 1'b1);
            if (j == 2) begin
                chk("restart_fs", 32'(frame_start), 32'd1);
                chk("restart_pix", 32'(pix_data), 32'd0);
            end
        end
        for (int j = 0; j < 3; j++) begin
            step(1'b0, 1'b1, 1'b0);
            if (j == 0) begin
                chk("rst_pix_de", 32'(pix_de), 32'd0);
                chk("rst_hsync_n", 32'(hsync_n), 32'd1);
            end
        end
        for (int j = 0; j < 900; j++) begin
            step(1'b1, 1'b1, 1'b1);
            if (j == 2) begin
                chk("post_rst_de", 32'(pix_de), 32'd1);
                chk("post_rst_pix", 32'(pix_data), 32'd0);
                chk("post_rst_fs", 32'(frame_start), 32'd1);
            end
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
